spi_mem_ctrl: RTL

- Parametrised SPI (mode 0) memory controller serving N_CS serial memories (PSRAM, NOR flash, etc.) behind one valid/ready request port from the core's load/store unit.
- Decodes the address into a device and a device-local offset, then issues a single-transfer READ/WRITE frame.
- Supports byte/half/word accesses in little-endian byte order, a programmable SCK divider, a per-device write-protect mask and error responses.

---
 rtl/spi_mem_ctrl_pkg.sv | 32 +++
 rtl/spi_mem_ctrl_if.sv | 11 +
 rtl/spi_mem_ctrl_bit_engine.sv | 50 +++++
 rtl/spi_mem_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/spi_mem_ctrl_pkg.sv
// spi_mem_pkg: shared commands, size encodings, FSM states and helpers for spi_mem_ctrl.
// FAST_READ_EN adds the DUMMY state and selects the 0x0B read command.
package spi_mem_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
`ifdef FAST_READ_EN
  localparam logic [7:0] CMD_RD = CMD_FAST_READ;
`else
  localparam logic [7:0] CMD_RD = CMD_READ;
`endif
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
`ifdef FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA,
    S_GAP,
    S_ERR
  } state_t;
  function automatic logic [2:0] size_to_bytes(input logic [1:0] s);
    return s == SZ_WORD ? 3'd4 : s == SZ_BYTE ? 3'd1 : s == SZ_HALF ? 3'd2 : 3'd0;
  endfunction
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/spi_mem_ctrl_if.sv
// spi_mem_ctrl_if: load/store request and response port of the SPI memory controller.
interface spi_mem_ctrl_if #(parameter int ADDR_W = 24) ();
  logic req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0] req_size;
  logic [31:0] req_wdata, rsp_rdata;
  modport master(output req_valid, req_addr, req_we, req_size, req_wdata,
                 input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_addr, req_we, req_size, req_wdata,
                output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/spi_mem_ctrl_bit_engine.sv
// spi_bit_engine: shifts one left-aligned field of up to 32 bits out on mosi and in from miso.
// A start in the done cycle chains the next field with no idle SCK period.
module spi_bit_engine #(parameter int SCK_DIV = 1) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  width,
  input  logic [31:0] tx,
  input  logic        miso,
  output logic        done,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] rx
);
  localparam int DW = $clog2(SCK_DIV + 1);
  logic busy, phase, half_end;
  logic [DW-1:0] div;
  logic [5:0] cnt;
  logic [31:0] sr;
  assign half_end = busy && div == DW'(SCK_DIV - 1);
  assign done = half_end && phase && cnt == 6'd1;
  assign sck = busy && phase;
  assign mosi = busy && sr[31];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      phase <= 1'b0;
      div <= '0;
      cnt <= '0;
      sr <= '0;
      rx <= '0;
    end else begin
      if (half_end && !phase) rx <= {rx[30:0], miso};
      if (start) begin
        busy <= 1'b1;
        phase <= 1'b0;
        div <= '0;
        cnt <= width;
        sr <= tx;
      end else if (half_end) begin
        div <= '0;
        phase <= !phase;
        if (phase) begin
          sr <= sr << 1;
          cnt <= cnt - 6'd1;
          busy <= cnt != 6'd1;
        end
      end else if (busy) div <= div + DW'(1);
    end
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI mode-0 memory controller: address decode, error checks and frame FSM.
// Define FAST_READ_EN for 0x0B reads with 8 dummy SCK cycles before the data phase.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int N_CS = 2,
  parameter int SCK_DIV = 1,
  parameter int CS_GAP = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  spi_mem_ctrl_if.slave            bus,
  input  logic [N_CS*ADDR_W-1:0]   dev_base,
  input  logic [N_CS-1:0]          wp_mask,
  output logic [N_CS-1:0]          cs_n,
  output logic                     sck,
  output logic                     mosi,
  input  logic                     miso
);
  localparam int SW = N_CS > 1 ? $clog2(N_CS) : 1;
  localparam int GW = $clog2(CS_GAP + 1);
  state_t state, state_n;
  logic [SW-1:0] sel, dev;
  logic [ADDR_W-1:0] base, off;
  logic [2:0] nbytes;
  logic [31:0] wswap, tx, rx;
  logic [5:0] width;
  logic [GW-1:0] gap;
  logic we, accept, err, start, done, data_done;
  always_comb begin
    sel = '0;
    base = dev_base[ADDR_W-1:0];
    for (int i = 1; i < N_CS; i++)
      if (bus.req_addr >= dev_base[i*ADDR_W +: ADDR_W]) begin
        sel = SW'(i);
        base = dev_base[i*ADDR_W +: ADDR_W];
      end
  end
  assign err = bus.req_addr < dev_base[ADDR_W-1:0] || bus.req_size == 2'b11 || (bus.req_we && wp_mask[sel]);
  assign accept = bus.req_valid && state == S_IDLE;
  assign bus.req_ready = state == S_IDLE;
  assign data_done = state == S_DATA && done;
  assign cs_n = state inside {S_CMD, S_ADDR, S_DATA
`ifdef FAST_READ_EN
    , S_DUMMY
`endif
  } ? ~(N_CS'(1) << dev) : '1;
  always_comb begin
    state_n = state;
    start = 1'b0;
    width = '0;
    tx = '0;
    case (state)
      S_IDLE: if (accept) begin
        state_n = err ? S_ERR : S_CMD;
        start = !err;
        width = 6'd8;
        tx = {bus.req_we ? CMD_WRITE : CMD_RD, 24'h0};
      end
      S_CMD: if (done) begin
        state_n = S_ADDR;
        start = 1'b1;
        width = 6'(ADDR_W);
        tx = 32'(off) << (32 - ADDR_W);
      end
`ifdef FAST_READ_EN
      S_ADDR: if (done) begin
        state_n = we ? S_DATA : S_DUMMY;
        start = 1'b1;
        width = we ? {nbytes, 3'b0} : 6'd8;
        tx = we ? wswap : '0;
      end
      S_DUMMY: if (done) begin
        state_n = S_DATA;
        start = 1'b1;
        width = {nbytes, 3'b0};
      end
`else
      S_ADDR: if (done) begin
        state_n = S_DATA;
        start = 1'b1;
        width = {nbytes, 3'b0};
        tx = we ? wswap : '0;
      end
`endif
      S_DATA: state_n = done ? S_GAP : S_DATA;
      S_GAP: state_n = gap == GW'(CS_GAP - 1) ? S_IDLE : S_GAP;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      dev <= '0;
      off <= '0;
      we <= 1'b0;
      nbytes <= '0;
      wswap <= '0;
      gap <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state <= state_n;
      gap <= state == S_GAP ? gap + GW'(1) : '0;
      bus.rsp_valid <= (accept && err) || data_done;
      if (accept) begin
        dev <= sel;
        off <= bus.req_addr - base;
        we <= bus.req_we;
        nbytes <= size_to_bytes(bus.req_size);
        wswap <= byte_swap(bus.req_wdata);
      end
      if (accept && err) begin
        bus.rsp_err <= 1'b1;
        bus.rsp_rdata <= '0;
      end
      // the received field sits in the low bits, first byte highest; left-align then swap
      if (data_done) begin
        bus.rsp_err <= 1'b0;
        bus.rsp_rdata <= we ? '0 : byte_swap(rx << (6'd32 - {nbytes, 3'b0}));
      end
    end
  spi_bit_engine #(.SCK_DIV(SCK_DIV)) u_eng (
    .clk(clk), .reset(reset), .start(start), .width(width), .tx(tx),
    .miso(miso), .done(done), .sck(sck), .mosi(mosi), .rx(rx)
  );
endmodule
